kbd_fifo: RTL
=============

# kbd_fifo

PS/2 keyboard receiver with a small scan-code FIFO. It is the source of the `key_data` word that the IO decoder returns for the 0x003xxxxx address window, and it consumes that decoder's `read_key` strobe to pop one byte per CPU load. It deserialises PS/2 frames, checks their framing and parity, buffers valid bytes, and exposes the head byte together with status flags.

## Interface
- `DEPTH`, 8: FIFO entries; must be a power of two, 2..64.
- `TIMEOUT`, 5000: idle clk cycles after which a partial frame is discarded.
- `clk` in 1: system clock; all logic is on the rising edge.
- `clrn` in 1: reset, synchronous, active-low.
- `ps2_clk` in 1: raw PS/2 clock from the pad; asynchronous.
- `ps2_data` in 1: raw PS/2 data from the pad; asynchronous.
- `read_key` in 1: level-high while the CPU addresses the keyboard window.
- `key_data` out 32: `{22'b0, overflow, valid, head[7:0]}`.
- `frame_err` out 1: one-cycle pulse when a received frame is rejected.

## Operation
- **Input sync:** `ps2_clk` and `ps2_data` each pass through 2 flops. A falling edge is detected when the previous sampled `ps2_clk` is 1 and the current one is 0. Bits are sampled on that edge.
- **Receive FSM:**
  - IDLE: a falling edge with data=0 (start bit) moves to SHIFT with `bitcnt`=0. A falling edge with data=1 is ignored.
  - SHIFT: each falling edge shifts data into bit[bitcnt] (LSB first) and increments `bitcnt`. After the 8th bit, move to PARITY.
  - PARITY: capture the bit on the next falling edge, then move to STOP.
  - STOP: capture the bit on the next falling edge. The frame is accepted only if stop=1 and the XOR of the 8 data bits and the parity bit is 1 (odd parity). If accepted, issue a push request; if not, pulse `frame_err`. Either way, return to IDLE.
  - Timeout: in any non-IDLE state, an idle counter runs and reloads to 0 on every falling edge. When it reaches `TIMEOUT`, the FSM returns to IDLE, the partial byte is dropped, and `frame_err` pulses.
- **FIFO:** circular buffer with `log2(DEPTH)`-bit read/write pointers plus a count register of width `log2(DEPTH)+1`.
  - `valid` = (count != 0).
  - `head` = mem[rd_ptr]; it is 0x00 when empty.
- **Pop:** `pop = read_key & ~read_key_q & valid`, where `read_key_q` is `read_key` registered. Only one pop occurs per contiguous high period of `read_key`, so a multi-cycle access pops exactly once.
- **Push:** accepted byte writes mem[wr_ptr]. When full:
  - push alone: the byte is dropped and `overflow` is set.
  - push and pop in the same cycle: both take effect, count is unchanged, and `overflow` is not set.
- **Overflow clear:** `overflow` is sticky. It clears on the cycle after any pop, unless an overflow is set in that same cycle; set wins.
- **Pointers:** wrap modulo `DEPTH`.
- **Empty-pop:** an edge of `read_key` while empty has no effect on pointers or flags.

## Timing
- **Reset** (`clrn`=0 at a clk edge): FSM goes to IDLE. `bitcnt`, pointers, count, idle counter, `read_key_q`, and the sync flops are cleared. Sync flops reset to 1, the bus-idle level. `overflow`=0 and `frame_err`=0. `key_data` reads 0x00000000 on the following cycle. Memory contents are don't-care.
- Reset mid-frame discards the partial frame; no push occurs.
- Pad-to-edge-detect latency: 3 clk cycles.
- The push is registered on the cycle after the stop-bit edge is detected. `valid` and `head` update 1 cycle after that.
- `key_data` is driven combinationally from the registers and stays stable for the whole cycle in which `read_key` first rises. The CPU therefore samples the pre-pop byte. The next head is visible from the following cycle.
- `frame_err` is exactly 1 cycle wide.
- PS/2 edge spacing is at least 30 µs, far longer than any internal latency, so the design needs no back-pressure to the device.

## Test plan
- **Single frame:** send 0x1C (data bits 0,0,1,1,1,0,0,0 LSB first; parity=0; stop=1) -> after the stop bit, `key_data`=0x0000011C. A 3-cycle `read_key` pulse pops once, and `key_data`=0x00000000 afterwards.
- **Parity error:** send 0x1C with parity=1 -> one `frame_err` pulse; `valid` stays 0. A following good 0xF0 frame yields `key_data`=0x000001F0.
- **Fill and overflow:** send 9 valid bytes 0x01..0x09 with no reads -> `key_data`=0x00000301 (overflow=1, head=0x01). Read 8 times and get 0x01..0x08 in order; overflow is 0 after the first pop, and the FIFO is empty at the end.
- **Push/pop collision at full:** with 8 entries queued, align the `read_key` rising edge with the stop-bit push cycle -> count stays 8, `overflow` stays 0, the head advances to the 2nd byte, and the new byte is at the tail.
- **Timeout:** send start plus 4 bits, then stop toggling for `TIMEOUT`+1 cycles -> `frame_err` pulses and the FSM returns to IDLE. A following full 0x5A frame is received correctly.
- **Reset mid-frame:** drive `clrn`=0 for 1 cycle after the 5th data bit, while one byte is already queued -> `key_data`=0 on the next cycle, and no byte appears once the rest of the frame arrives.

Source files
------------

// File: rtl/kbd_fifo.sv
// ===========================================================================
// kbd_fifo : PS/2 keyboard receiver feeding a small scan-code FIFO.
// Revision : 1.0
// ===========================================================================
`default_nettype none

module kbd_fifo #(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 5000
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  input  logic        read_key,
  output logic [31:0] key_data,
  output logic        frame_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [PW:0]   FULL_CNT = (PW + 1)'(DEPTH);
  localparam logic [TW-1:0] TO_CNT   = TW'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  logic ps2c_s1_q, ps2c_s2_q, ps2c_prev_q, ps2d_s1_q, ps2d_s2_q;
  logic fall;

  always_ff @(posedge clk) begin
    if (!clrn) begin
      ps2c_s1_q   <= 1'b1;
      ps2c_s2_q   <= 1'b1;
      ps2c_prev_q <= 1'b1;
      ps2d_s1_q   <= 1'b1;
      ps2d_s2_q   <= 1'b1;
    end else begin
      ps2c_s1_q   <= ps2_clk;
      ps2c_s2_q   <= ps2c_s1_q;
      ps2c_prev_q <= ps2c_s2_q;
      ps2d_s1_q   <= ps2_data;
      ps2d_s2_q   <= ps2d_s1_q;
    end
  end

  assign fall = ps2c_prev_q & ~ps2c_s2_q;

  state_t        state_q, state_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          parity_q, parity_d;
  logic [TW-1:0] idle_q, idle_d;
  logic          push_q, push_d;
  logic [7:0]    push_byte_q, push_byte_d;
  logic          err_q, err_d;

  always_ff @(posedge clk) begin
    if (!clrn) begin
      state_q     <= S_IDLE;
      bitcnt_q    <= '0;
      shift_q     <= '0;
      parity_q    <= 1'b0;
      idle_q      <= '0;
      push_q      <= 1'b0;
      push_byte_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
      idle_q      <= idle_d;
      push_q      <= push_d;
      push_byte_q <= push_byte_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bitcnt_d    = bitcnt_q;
    shift_d     = shift_q;
    parity_d    = parity_q;
    idle_d      = '0;
    push_d      = 1'b0;
    push_byte_d = push_byte_q;
    err_d       = 1'b0;
    if (state_q != S_IDLE && !fall) idle_d = idle_q + 1'b1;
    case (state_q)
      S_IDLE: if (fall && !ps2d_s2_q) begin
        state_d  = S_SHIFT;
        bitcnt_d = '0;
      end
      S_SHIFT: if (fall) begin
        shift_d[bitcnt_q] = ps2d_s2_q;
        bitcnt_d          = bitcnt_q + 1'b1;
        if (bitcnt_q == 3'd7) state_d = S_PARITY;
      end
      S_PARITY: if (fall) begin
        parity_d = ps2d_s2_q;
        state_d  = S_STOP;
      end
      S_STOP: if (fall) begin
        state_d = S_IDLE;
        // Good frame: stop bit high and odd parity over data plus parity bit.
        if (ps2d_s2_q && (^{shift_q, parity_q})) begin
          push_d      = 1'b1;
          push_byte_d = shift_q;
        end else begin
          err_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (state_q != S_IDLE && !fall && idle_q == TO_CNT) begin
      state_d = S_IDLE;
      idle_d  = '0;
      err_d   = 1'b1;
    end
  end

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [PW:0]   count_q;
  logic          read_key_q, overflow_q;
  logic          valid, full, pop, push_ok, ovf_set;

  assign valid   = (count_q != '0);
  assign full    = (count_q == FULL_CNT);
  assign pop     = read_key & ~read_key_q & valid;
  assign push_ok = push_q & (~full | pop);
  assign ovf_set = push_q & full & ~pop;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= push_byte_q;
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      read_key_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      read_key_q <= read_key;
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      // A set in the same cycle as a pop keeps the flag asserted.
      if (ovf_set)  overflow_q <= 1'b1;
      else if (pop) overflow_q <= 1'b0;
    end
  end

  assign key_data  = {22'b0, overflow_q, valid, (valid ? mem[rd_ptr_q] : 8'h00)};
  assign frame_err = err_q;

endmodule

`default_nettype wire
